// File: rtl/cyclic_queue_sequencer.sv
// rtl/cyclic_queue_sequencer.sv - loads one block into a CyclicQueue and replays it cfg_passes times
// Optional CYCQ_SEQ_PERF_EN adds the stall_cnt output-backpressure counter.
module cyclic_queue_sequencer #(
  parameter int DATA_W = 32,
  parameter int QDEPTH = 64,
  parameter int LEN_W  = 7,
  parameter int PASS_W = 8
) (
`ifdef CYCQ_SEQ_PERF_EN
  output logic [15:0]       stall_cnt,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              q_rst_n,
  output logic              q_en,
  output logic              q_mode,
  output logic [DATA_W-1:0] q_data_in,
  input  logic [DATA_W-1:0] q_data_out
);

  localparam logic [LEN_W:0]    DEPTH_C  = (LEN_W+1)'(QDEPTH);
  localparam logic [LEN_W:0]    LEN_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [PASS_W-1:0] PASS_ONE = {{(PASS_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_STREAM, S_FLUSH} state_t;
  state_t state, state_nx;

  logic [LEN_W:0]              len_q, wr_cnt, rd_idx;
  logic [PASS_W-1:0]           passes_q, pass_cnt;
  logic [1:0][DATA_W-1:0]      fifo_data;
  logic [1:0]                  fifo_last;
  logic                        head, tail;
  logic [1:0]                  fifo_cnt;
  logic                        pend, pend_last;
  logic                        err_q, done_q;
  logic                        cfg_bad, wr_fire, pop, real_slot, room;
  logic                        rd_fire, real_fire, last_rd, flush_ok;

  assign cfg_bad   = (cfg_len == '0) || ({1'b0, cfg_len} > DEPTH_C) || (cfg_passes == '0);
  assign in_ready  = (state == S_LOAD);
  assign wr_fire   = in_ready && in_valid;
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_data[head] : '0;
  assign out_last  = out_valid && fifo_last[head];

  // Occupancy is counted after this cycle's pop so an unstalled stream sustains one word per cycle.
  assign real_slot = (rd_idx < len_q);
  assign room      = (({1'b0, fifo_cnt} + {2'b0, pend}) - {2'b0, pop}) < 3'd2;
  assign rd_fire   = (state == S_STREAM) && (!real_slot || room);
  assign real_fire = rd_fire && real_slot;
  assign last_rd   = (rd_idx == DEPTH_C - LEN_ONE) && (pass_cnt == passes_q - PASS_ONE);
  assign flush_ok  = (state == S_FLUSH) && (fifo_cnt == 2'd0) && !pend;

  assign q_en      = wr_fire || rd_fire;
  assign q_mode    = wr_fire;
  assign q_data_in = in_ready ? in_data : '0;
  assign q_rst_n   = rst && (state != S_CLR);
  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start && !cfg_bad) state_nx = S_CLR;
      S_CLR:    state_nx = S_LOAD;
      S_LOAD:   if (wr_fire && (wr_cnt == len_q - LEN_ONE)) state_nx = S_STREAM;
      S_STREAM: if (rd_fire && last_rd) state_nx = S_FLUSH;
      S_FLUSH:  if (flush_ok) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      passes_q  <= '0;
      wr_cnt    <= '0;
      rd_idx    <= '0;
      pass_cnt  <= '0;
      fifo_data <= '0;
      fifo_last <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      fifo_cnt  <= 2'd0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      err_q  <= (state == S_IDLE) && start && cfg_bad;
      done_q <= flush_ok;
      if ((state == S_IDLE) && start && !cfg_bad) begin
        len_q    <= {1'b0, cfg_len};
        passes_q <= cfg_passes;
      end
      if (state == S_CLR) begin
        wr_cnt   <= '0;
        rd_idx   <= '0;
        pass_cnt <= '0;
      end
      if (wr_fire) wr_cnt <= wr_cnt + LEN_ONE;
      // Reads always walk the whole queue so the read pointer is back at 0 for the next pass.
      if (rd_fire) begin
        if (rd_idx == DEPTH_C - LEN_ONE) begin
          rd_idx   <= '0;
          pass_cnt <= pass_cnt + PASS_ONE;
        end else begin
          rd_idx <= rd_idx + LEN_ONE;
        end
      end
      pend      <= real_fire;
      pend_last <= real_fire && (rd_idx == len_q - LEN_ONE) && (pass_cnt == passes_q - PASS_ONE);
      if (pend) begin
        fifo_data[tail] <= q_data_out;
        fifo_last[tail] <= pend_last;
        tail            <= ~tail;
      end
      if (pop) head <= ~head;
      fifo_cnt <= (fifo_cnt + {1'b0, pend}) - {1'b0, pop};
    end
  end

`ifdef CYCQ_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'd0;
    end else if (state == S_CLR) begin
      stall_cnt <= 16'd0;
    end else if (busy && out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
